fmap_reader: RTL

FMAP_READER -- requirements
Module: fmap_reader

---
 rtl/fmap_reader_if.sv | 24 ++
 rtl/fmap_reader.sv | 129 ++++++++++++
 2 files changed

// File: rtl/fmap_reader_if.sv
// Feature-map reader bus bundle: BRAM port-B read side plus the output beat stream.
interface fmap_reader_if #(
    parameter int DATA_W = 20,
    parameter int OUT_W  = 17
);
    logic              enb;
    logic [7:0]        addrb;
    logic [DATA_W-1:0] doutb;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic [1:0]        out_ch;
    logic [5:0]        out_pos;
    logic              out_last;

    modport master (
        output enb, addrb, out_valid, out_data, out_ch, out_pos, out_last,
        input  doutb, out_ready
    );
    modport slave (
        input  enb, addrb, out_valid, out_data, out_ch, out_pos, out_last,
        output doutb, out_ready
    );
endinterface

// File: rtl/fmap_reader.sv
// Streams N_CH x N_POS BRAM words out through a 2-entry tagged FIFO with backpressure.
// Optional macro FMAP_READER_CLAMP_EN clamps output data to 255.
module fmap_reader #(
    parameter int N_CH   = 3,
    parameter int N_POS  = 36,
    parameter int DATA_W = 20,
    parameter int OUT_W  = 17
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    fmap_reader_if.master bus
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic [1:0]       ch;
        logic [5:0]       pos;
        logic             last;
    } beat_t;

    state_t state, state_n;
    logic [1:0] ch;
    logic [5:0] pos;
    logic last_addr, issue, push, pop;
    logic rd_vld, rd_last;
    logic [1:0] rd_ch;
    logic [5:0] rd_pos;
    beat_t fifo [2];
    beat_t head;
    logic wr_ptr, rd_ptr;
    logic [1:0] count;
    logic [DATA_W-1:0] word;
    logic [OUT_W-1:0] raw, wdata;
    logic unused_word;

    assign word        = bus.doutb;
    assign raw         = word[OUT_W-1:0];
    assign unused_word = ^word;
`ifdef FMAP_READER_CLAMP_EN
    assign wdata = (raw > OUT_W'(255)) ? OUT_W'(255) : raw;
`else
    assign wdata = raw;
`endif

    assign last_addr = (ch == 2'(N_CH - 1)) && (pos == 6'(N_POS - 1));
    assign head      = fifo[rd_ptr];
    assign pop       = (count != 2'd0) && bus.out_ready;
    assign push      = rd_vld;
    // Room is counted including the word still coming back from BRAM.
    assign issue     = (state == READ) && (((count + {1'b0, rd_vld}) < 2'd2) || pop);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = READ;
            READ:    if (issue && last_addr) state_n = DRAIN;
            DRAIN:   if (pop && head.last) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ch  <= 2'd0;
            pos <= 6'd0;
        end else if (issue) begin
            if (pos == 6'(N_POS - 1)) begin
                pos <= 6'd0;
                ch  <= last_addr ? 2'd0 : ch + 2'd1;
            end else begin
                pos <= pos + 6'd1;
            end
        end
    end

    // Tag of the read in flight; pairs with doutb on the following cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_vld  <= 1'b0;
            rd_ch   <= 2'd0;
            rd_pos  <= 6'd0;
            rd_last <= 1'b0;
        end else begin
            rd_vld <= issue;
            if (issue) begin
                rd_ch   <= ch;
                rd_pos  <= pos;
                rd_last <= last_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fifo[0] <= '0;
            fifo[1] <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= 2'd0;
        end else begin
            if (push) begin
                fifo[wr_ptr] <= '{data: wdata, ch: rd_ch, pos: rd_pos, last: rd_last};
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign bus.enb       = issue;
    assign bus.addrb     = {ch, pos};
    assign bus.out_valid = (count != 2'd0);
    assign bus.out_data  = head.data;
    assign bus.out_ch    = head.ch;
    assign bus.out_pos   = head.pos;
    assign bus.out_last  = head.last;
    assign busy          = (state != IDLE);
    assign done          = (state == DONE);
endmodule
